// File: rtl/c32_arb_pkg.sv
// Shared definitions for the c32 memory arbiter: state encoding, owner
// codes and counter width.
package c32_arb_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } arb_state_t;

    // Grantee codes as driven on the owner output.
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    // Width of the wait-state and DMA burst counters.
    localparam int CNT_W = 4;

endpackage

// File: rtl/c32_memarb.sv
// Single-port memory arbiter/sequencer for the c32 core. One access is in
// flight at a time: IDLE arbitrates, BUSY covers the memory wait states and
// DONE presents the completion pulse while the requester moves on.
//
// Requester handshake: the CPU is treated as always requesting and its
// cpu_a/cpu_o/cpu_w are sampled in IDLE; cpu_ce is a one-cycle pulse marking
// completion. The DMA side holds dma_req with stable dma_a/dma_d/dma_w until
// it sees the one-cycle dma_ack; read data (cpu_i / dma_q) is valid with the
// pulse and held until the next read for that requester completes.
module c32_memarb
    import c32_arb_pkg::*;
#(
    parameter int WAIT      = 1,
    parameter int DMA_BURST = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] cpu_a,
    input  logic [31:0] cpu_o,
    input  logic        cpu_w,
    output logic [31:0] cpu_i,
    output logic        cpu_ce,
    input  logic        dma_req,
    input  logic [31:0] dma_a,
    input  logic [31:0] dma_d,
    input  logic        dma_w,
    output logic        dma_ack,
    output logic [31:0] dma_q,
    output logic [31:0] mem_a,
    output logic [31:0] mem_d,
    output logic        mem_w,
    input  logic [31:0] mem_q,
    output logic        owner
);

    localparam logic [CNT_W-1:0] WAIT_C  = CNT_W'(WAIT);
    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(DMA_BURST);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic             owner_q, owner_d;
    logic             wr_q, wr_d;
    logic [31:0]      mem_a_q, mem_a_d;
    logic [31:0]      mem_d_q, mem_d_d;
    logic             mem_w_q, mem_w_d;
    logic [31:0]      cpu_i_q, cpu_i_d;
    logic [31:0]      dma_q_q, dma_q_d;
    logic             cpu_ce_q, cpu_ce_d;
    logic             dma_ack_q, dma_ack_d;

    // Next-state and next-output logic for the IDLE/BUSY/DONE sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        burst_d   = burst_q;
        owner_d   = owner_q;
        wr_d      = wr_q;
        mem_a_d   = mem_a_q;
        mem_d_d   = mem_d_q;
        mem_w_d   = 1'b0;
        cpu_i_d   = cpu_i_q;
        dma_q_d   = dma_q_q;
        cpu_ce_d  = 1'b0;
        dma_ack_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // DMA wins unless it has used up its burst allowance.
                if (dma_req && (burst_q < BURST_C)) begin
                    owner_d = OWN_DMA;
                    burst_d = burst_q + 1'b1;
                    mem_a_d = dma_a;
                    mem_d_d = dma_d;
                    wr_d    = dma_w;
                end else begin
                    owner_d = OWN_CPU;
                    burst_d = '0;
                    mem_a_d = cpu_a;
                    mem_d_d = cpu_o;
                    wr_d    = cpu_w;
                end
                mem_w_d = wr_d;
                cnt_d   = WAIT_C;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                // mem_w defaults low, so the strobe lasts only the first BUSY cycle.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (!wr_q) begin
                        if (owner_q == OWN_DMA) dma_q_d = mem_q;
                        else                    cpu_i_d = mem_q;
                    end
                    if (owner_q == OWN_DMA) dma_ack_d = 1'b1;
                    else                    cpu_ce_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any access immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            burst_q   <= '0;
            owner_q   <= OWN_CPU;
            wr_q      <= 1'b0;
            mem_a_q   <= '0;
            mem_d_q   <= '0;
            mem_w_q   <= 1'b0;
            cpu_i_q   <= '0;
            dma_q_q   <= '0;
            cpu_ce_q  <= 1'b0;
            dma_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            burst_q   <= burst_d;
            owner_q   <= owner_d;
            wr_q      <= wr_d;
            mem_a_q   <= mem_a_d;
            mem_d_q   <= mem_d_d;
            mem_w_q   <= mem_w_d;
            cpu_i_q   <= cpu_i_d;
            dma_q_q   <= dma_q_d;
            cpu_ce_q  <= cpu_ce_d;
            dma_ack_q <= dma_ack_d;
        end
    end

    assign cpu_i   = cpu_i_q;
    assign cpu_ce  = cpu_ce_q;
    assign dma_ack = dma_ack_q;
    assign dma_q   = dma_q_q;
    assign mem_a   = mem_a_q;
    assign mem_d   = mem_d_q;
    assign mem_w   = mem_w_q;
    assign owner   = owner_q;

endmodule

// File: tb/tb_c32_memarb.sv
// Bench for c32_memarb: a WAIT=1/DMA_BURST=4 instance driven with random CPU
// and DMA traffic, plus a WAIT=3 instance doing CPU-only reads.
module tb_c32_memarb;

    localparam int WAIT   = 1;
    localparam int BURST  = 4;
    localparam int WAIT2  = 3;
    localparam int W      = 98;
    localparam int NSTEPS = 60;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // ---------------- main DUT ----------------
    logic [31:0] cpu_a = '0, cpu_o = '0, dma_a = '0, dma_d = '0;
    logic        cpu_w = 1'b0, dma_req = 1'b0, dma_w = 1'b0;
    logic [31:0] cpu_i, dma_q, mem_a, mem_d;
    logic [31:0] mem_q = '0;
    logic        cpu_ce, dma_ack, mem_w, owner;

    c32_memarb #(.WAIT(WAIT), .DMA_BURST(BURST)) u_dut (
        .clock(clock), .reset(reset),
        .cpu_a(cpu_a), .cpu_o(cpu_o), .cpu_w(cpu_w), .cpu_i(cpu_i), .cpu_ce(cpu_ce),
        .dma_req(dma_req), .dma_a(dma_a), .dma_d(dma_d), .dma_w(dma_w),
        .dma_ack(dma_ack), .dma_q(dma_q),
        .mem_a(mem_a), .mem_d(mem_d), .mem_w(mem_w), .mem_q(mem_q), .owner(owner)
    );

    // ---------------- WAIT=3 DUT, CPU only ----------------
    logic [31:0] cpu_a2 = 32'h0000_0010;
    logic [31:0] cpu_i2, dma_q2, mem_a2, mem_d2;
    logic [31:0] mem_q2 = '0;
    logic        cpu_ce2, dma_ack2, mem_w2, owner2;
    logic [31:0] zero32 = '0;
    logic        zero1  = 1'b0;

    c32_memarb #(.WAIT(WAIT2), .DMA_BURST(BURST)) u_dut2 (
        .clock(clock), .reset(reset),
        .cpu_a(cpu_a2), .cpu_o(zero32), .cpu_w(zero1), .cpu_i(cpu_i2), .cpu_ce(cpu_ce2),
        .dma_req(zero1), .dma_a(zero32), .dma_d(zero32), .dma_w(zero1),
        .dma_ack(dma_ack2), .dma_q(dma_q2),
        .mem_a(mem_a2), .mem_d(mem_d2), .mem_w(mem_w2), .mem_q(mem_q2), .owner(owner2)
    );

    // ---------------- counters and check helper ----------------
    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        logic [15:0] lo;
        lo = a[15:0];
        return {lo, ~lo} ^ 32'h5A5A_1234;
    endfunction

    // ---------------- memory device models ----------------
    // Data is only valid once mem_a has been stable for WAIT cycles.
    logic [31:0] sim_mem [logic [31:0]];
    logic [31:0] last_a = '0, last_a2 = '0;
    int          age = 0, age2 = 0;

    function automatic logic [31:0] sim_rd(input logic [31:0] a);
        if (sim_mem.exists(a)) return sim_mem[a];
        return init_val(a);
    endfunction

    always @(posedge clock) begin
        if (mem_w) sim_mem[mem_a] = mem_d;
    end

    always @(negedge clock) begin
        if (mem_a == last_a) begin
            if (age < 100) age++;
        end else age = 0;
        last_a = mem_a;
        mem_q  = (age >= WAIT) ? sim_rd(mem_a) : (32'hDEAD_0000 ^ mem_a);
        if (mem_a2 == last_a2) begin
            if (age2 < 100) age2++;
        end else age2 = 0;
        last_a2 = mem_a2;
        mem_q2  = (age2 >= WAIT2) ? init_val(mem_a2) : (32'hBEEF_0000 ^ mem_a2);
    end

    // ---------------- reference model ----------------
    logic [31:0] model_mem [logic [31:0]];
    int          burst_m = 0;
    logic [31:0] last_cpu_rd = '0, last_dma_rd = '0;
    logic [W-1:0] exp_q[$];

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return init_val(a);
    endfunction

    // Decide the next grant from the requests now presented and queue its outcome.
    task automatic issue();
        logic        own, wr;
        logic [31:0] a, d, r;
        if (dma_req && burst_m < BURST) begin
            own = 1'b1; burst_m++;
            a = dma_a; d = dma_d; wr = dma_w;
        end else begin
            own = 1'b0; burst_m = 0;
            a = cpu_a; d = cpu_o; wr = cpu_w;
        end
        if (wr) begin
            model_mem[a] = d;
            r = own ? last_dma_rd : last_cpu_rd;
        end else begin
            r = model_rd(a);
            if (own) last_dma_rd = r;
            else     last_cpu_rd = r;
        end
        exp_q.push_back({own, wr, a, d, r});
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic mon_en = 1'b0;
    int   prev_done = -1, wr_seen = 0, done_cnt = 0;
    logic obs[$];
    int   prev_done2 = -1, done2 = 0;

    always @(negedge clock) begin
        logic [W-1:0] e;
        if (reset) begin
            prev_done  = -1;
            prev_done2 = -1;
            wr_seen    = 0;
        end else if (mon_en) begin
            if (cpu_ce && dma_ack) chk("both_pulses", 32'(cpu_ce & dma_ack), 32'd0);
            if (mem_w) begin
                if (exp_q.size() == 0) chk("mem_w_unexpected", 32'(mem_w), 32'd0);
                else begin
                    e = exp_q[0];
                    chk("mem_w_is_write", 32'(e[96]), 32'd1);
                    chk("mem_w_addr", mem_a, e[95:64]);
                    chk("mem_w_data", mem_d, e[63:32]);
                end
                wr_seen++;
            end
            if (cpu_ce || dma_ack) begin
                if (exp_q.size() == 0) chk("unexpected_done", 32'(cpu_ce | dma_ack), 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("done_kind", 32'(dma_ack), 32'(e[97]));
                    chk("owner_out", 32'(owner), 32'(e[97]));
                    chk("read_data", dma_ack ? dma_q : cpu_i, e[31:0]);
                    chk("write_strobes", 32'(wr_seen), 32'(e[96]));
                    chk("access_period", 32'(cyc - prev_done), 32'(WAIT + 3));
                    obs.push_back(dma_ack);
                end
                prev_done = cyc;
                wr_seen   = 0;
                done_cnt++;
            end
            // WAIT=3 instance: fixed period and data valid WAIT2 cycles after mem_a.
            chk("w3_no_dma_ack", 32'(dma_ack2), 32'd0);
            if (cpu_ce2) begin
                chk("w3_data", cpu_i2, init_val(cpu_a2));
                chk("w3_period", 32'(cyc - prev_done2), 32'(WAIT2 + 3));
                prev_done2 = cyc;
                done2++;
                cpu_a2 = 32'($urandom_range(0, 255)) << 2;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done(output logic ok);
        int t;
        t = 0;
        do begin
            @(posedge clock);
            #1;
            t++;
        end while (!(cpu_ce || dma_ack) && t < 20);
        ok = (cpu_ce || dma_ack);
        chk("done_timeout", 32'(ok), 32'd1);
    endtask

    task automatic new_dma();
        dma_req = 1'b1;
        dma_a   = 32'($urandom_range(0, 15)) << 2;
        dma_d   = $urandom;
        dma_w   = 1'($urandom_range(0, 1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic ok, who;
        logic [31:0] exp_pat;
        logic [31:0] got_pat;

        // Reset values.
        dma_req = 1'b1; dma_w = 1'b1; dma_a = 32'h80; dma_d = 32'hCAFE_F00D;
        repeat (3) @(negedge clock);
        chk("rst_mem_a",   mem_a, 32'd0);
        chk("rst_mem_d",   mem_d, 32'd0);
        chk("rst_cpu_i",   cpu_i, 32'd0);
        chk("rst_dma_q",   dma_q, 32'd0);
        chk("rst_cpu_ce",  32'(cpu_ce), 32'd0);
        chk("rst_dma_ack", 32'(dma_ack), 32'd0);
        chk("rst_mem_w",   32'(mem_w), 32'd0);
        chk("rst_owner",   32'(owner), 32'd0);

        // Reset during the first BUSY cycle of a DMA write.
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("abort_mem_w_before", 32'(mem_w), 32'd1);
        chk("abort_owner_before", 32'(owner), 32'd1);
        chk("abort_mem_a_before", mem_a, 32'h80);
        reset = 1'b1;
        #1;
        chk("abort_mem_w",   32'(mem_w), 32'd0);
        chk("abort_dma_ack", 32'(dma_ack), 32'd0);
        chk("abort_cpu_ce",  32'(cpu_ce), 32'd0);
        chk("abort_owner",   32'(owner), 32'd0);

        // First real access: CPU read of 0x100 with DMA idle.
        dma_req = 1'b0; dma_w = 1'b0;
        cpu_a = 32'h100; cpu_o = '0; cpu_w = 1'b0;
        sim_mem[32'h100]   = 32'h1234_5678;
        model_mem[32'h100] = 32'h1234_5678;
        repeat (2) @(negedge clock);
        burst_m = 0;
        issue();
        mon_en = 1'b1;
        reset  = 1'b0;
        @(posedge clock);
        #1;
        chk("first_grant_owner", 32'(owner), 32'd0);
        chk("first_grant_addr",  mem_a, 32'h100);

        for (int step = 1; step <= NSTEPS; step++) begin
            wait_done(ok);
            if (!ok) break;
            who = dma_ack;
            if (!who) begin
                if (step == 1) begin
                    cpu_a = 32'h40; cpu_o = 32'hDEAD_BEEF; cpu_w = 1'b1;
                end else begin
                    cpu_a = 32'($urandom_range(0, 15)) << 2;
                    cpu_o = $urandom;
                    cpu_w = 1'($urandom_range(0, 1));
                end
            end
            if (step >= 2 && step <= 11) begin
                // DMA kept requesting continuously through this stretch.
                if (!dma_req || who) new_dma();
            end else if (step > 11) begin
                if (who) begin
                    if ($urandom_range(0, 1) == 1) new_dma();
                    else dma_req = 1'b0;
                end else if (!dma_req && $urandom_range(0, 9) < 4) begin
                    new_dma();
                end
            end
            issue();
        end
        wait_done(ok);
        @(negedge clock);
        @(negedge clock);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("done_count", 32'(done_cnt), 32'(NSTEPS + 1));
        chk("w3_done_count_min", 32'(done2 >= 10), 32'd1);

        // Grants 3..12: C=0 D=1, expected D,D,D,D,C,D,D,D,D,C.
        exp_pat = 32'b1111011110;
        got_pat = '0;
        if (obs.size() >= 12) begin
            for (int i = 2; i < 12; i++) got_pat = {got_pat[30:0], obs[i]};
        end
        chk("burst_pattern", got_pat, exp_pat);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
